// File: rtl/hazard_ctrl_unit.sv
// Pipeline stall/flush controller for the 5-stage core: load-use, taken-branch and
// multi-cycle memory freeze handling, with a wait watchdog and perf counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_tkn,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              en_pc,
  output logic              en_if_id,
  output logic              en_id_ex,
  output logic              en_ex_mem,
  output logic              en_mem_wb,
  output logic              clr_if_id,
  output logic              clr_id_ex,
  output logic              clr_ex_mem,
  output logic              clr_mem_wb,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t          state, next_state;
  logic [WC_W-1:0] wait_cnt, next_wait_cnt;
  logic            freeze_c, load_use_c, branch_c;

  assign freeze_c   = mem_req & ~mem_ready;
  assign branch_c   = ex_branch_tkn;
  assign load_use_c = ex_mem_read & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // State register, wait watchdog counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= next_state;
      wait_cnt    <= next_wait_cnt;
      mem_timeout <= (next_state == HALT);
    end
  end

  // Next-state logic
  always_comb begin
    next_state    = state;
    next_wait_cnt = wait_cnt;
    case (state)
      RUN: begin
        if (freeze_c) begin
          next_state    = MEM_WAIT;
          next_wait_cnt = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze_c) begin
          if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
            next_state = HALT;
          end else begin
            next_wait_cnt = wait_cnt + WC_W'(1);
          end
        end else begin
          next_state    = RUN;
          next_wait_cnt = '0;
        end
      end
      HALT:    next_state = HALT;
      default: begin
        next_state    = RUN;
        next_wait_cnt = '0;
      end
    endcase
  end

  // Enables/clears: F > B > L > normal; reset clears every pipe register
  always_comb begin
    en_pc      = 1'b1;
    en_if_id   = 1'b1;
    en_id_ex   = 1'b1;
    en_ex_mem  = 1'b1;
    en_mem_wb  = 1'b1;
    clr_if_id  = 1'b0;
    clr_id_ex  = 1'b0;
    clr_ex_mem = 1'b0;
    clr_mem_wb = 1'b0;
    if (!rst_n) begin
      {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
      {clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb}    = '1;
    end else if (state == HALT) begin
      {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
    end else if (freeze_c) begin
      {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb} = '0;
      clr_mem_wb = 1'b1;
    end else if (branch_c) begin
      clr_if_id = 1'b1;
      clr_id_ex = 1'b1;
    end else if (load_use_c) begin
      en_pc     = 1'b0;
      en_if_id  = 1'b0;
      clr_id_ex = 1'b1;
    end
  end

  // Saturating performance counters, frozen in HALT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALT) begin
      if (!en_pc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!freeze_c && branch_c && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: reference model pushes expected controls and
// counters per driven cycle; they are popped and compared against the DUT mid-cycle.
module tb_hazard_ctrl_unit;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          SAT     = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic              ex_mem_read = 1'b0, ex_branch_tkn = 1'b0;
  logic              mem_req = 1'b0, mem_ready = 1'b0;
  logic              en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic              clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  hazard_ctrl_unit #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_tkn(ex_branch_tkn),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
    .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .clr_if_id(clr_if_id), .clr_id_ex(clr_id_ex),
    .clr_ex_mem(clr_ex_mem), .clr_mem_wb(clr_mem_wb),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [8:0] ctl;   // {en_pc,en_if_id,en_id_ex,en_ex_mem,en_mem_wb,clr_if_id,clr_id_ex,clr_ex_mem,clr_mem_wb}
    int         stall;
    int         flush;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: m_wait==0 means running, >0 counts consecutive freeze cycles
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_halt  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                      input logic [REG_AW-1:0] rd, input logic mr, input logic bt,
                      input logic rq, input logic rdy);
    exp_t       e;
    exp_t       got;
    bit         f, l;
    logic [8:0] act_ctl;
    @(negedge clk);
    rst_n = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_mem_read = mr; ex_branch_tkn = bt; mem_req = rq; mem_ready = rdy;
    e.stall = m_stall;
    e.flush = m_flush;
    e.tmo   = m_halt;
    f = rq && !rdy;
    l = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    if (!r) begin
      e.ctl = 9'b00000_1111;
      m_wait = 0; m_stall = 0; m_flush = 0; m_halt = 1'b0;
    end else if (m_halt) begin
      e.ctl = 9'b00000_0000;
    end else if (f) begin
      e.ctl = 9'b00000_0001;
      if (m_stall < SAT) m_stall++;
      if (m_wait == 0) m_wait = 1;
      else if (m_wait == int'(TIMEOUT) - 1) m_halt = 1'b1;
      else m_wait++;
    end else if (bt) begin
      e.ctl = 9'b11111_1100;
      if (m_flush < SAT) m_flush++;
      m_wait = 0;
    end else if (l) begin
      e.ctl = 9'b00111_0100;
      if (m_stall < SAT) m_stall++;
      m_wait = 0;
    end else begin
      e.ctl = 9'b11111_0000;
      m_wait = 0;
    end
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      act_ctl = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                 clr_if_id, clr_id_ex, clr_ex_mem, clr_mem_wb};
      check_val("ctl", 32'(act_ctl), 32'(got.ctl));
      check_val("stall_cnt", 32'(stall_cnt), 32'(got.stall));
      check_val("flush_cnt", 32'(flush_cnt), 32'(got.flush));
      check_val("mem_timeout", 32'(mem_timeout), 32'(got.tmo));
    end
  endtask

  task automatic nop();
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic freeze(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    nop(); nop();
    // load x5, ID reads rs2=x5: one bubble, then normal flow
    step(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    // rs1 hazard
    step(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    // x0 destination is never a hazard
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // non-load writing the same register is not a hazard
    step(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    // taken branch with coincident load-use: flush only
    step(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    nop();
    // 3-cycle memory wait then ready; ready without request is ignored
    freeze(3);
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    // freeze masks branch and load-use; release evaluates branch same cycle
    step(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    // release with load-use pending
    freeze(1);
    step(1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    nop();
    // three freezes (one below the limit) then release: no halt
    freeze(3);
    nop();
    // drive stall counter into saturation
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    nop();
    // watchdog: memory never ready, halt after 4th wait cycle, inputs ignored
    freeze(6);
    step(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    nop();
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    nop();
    // reset pulse mid MEM_WAIT restarts the watchdog
    freeze(2);
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    freeze(3);
    nop();
    // drive flush counter into saturation
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    // random traffic with occasional resets
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 11) != 0),
           REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
           REG_AW'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
